// File: rtl/ysyx_23060042_lsu_if.sv
// ysyx_23060042_lsu_if: valid/ready load-store request and response bundle between the EXU (master) and the LSU (slave)
interface ysyx_23060042_lsu_if;
  logic req_valid;
  logic req_ready;
  logic req_wen;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060042_lsu.sv
// ysyx_23060042_lsu: data-memory responder with fixed latency; ports clk, rst (sync active-high), bus (slave handshake: req_* in, rsp_* out)
module ysyx_23060042_lsu #(
  parameter int DEPTH = 4096,
  parameter logic [31:0] BASE = 32'h80000000,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ysyx_23060042_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic l_wen, l_uns;
  logic [1:0] l_size;
  logic [31:0] l_addr, l_wdata;
  logic a_wen, a_uns;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wdata, off;
  logic fire, acc, err;
  logic [AW-1:0] idx;
  logic [31:0] word, ext, wrep;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] mask;
  logic [31:0] rdata_q;
  logic err_q;
  logic [31:0] ram [DEPTH];
  assign fire = state == IDLE && bus.req_valid;
  // with a one-cycle latency the access happens on the acceptance edge itself, so the live bus is used instead of the latch
  assign acc = (fire && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
  assign a_wen = state == IDLE ? bus.req_wen : l_wen;
  assign a_uns = state == IDLE ? bus.req_unsigned : l_uns;
  assign a_size = state == IDLE ? bus.req_size : l_size;
  assign a_addr = state == IDLE ? bus.req_addr : l_addr;
  assign a_wdata = state == IDLE ? bus.req_wdata : l_wdata;
  assign off = a_addr - BASE;
  assign idx = off[AW+1:2];
  assign word = ram[idx];
  assign err = a_size == 2'b00 || (a_size == 2'b10 && a_addr[0]) || (a_size == 2'b11 && a_addr[1:0] != 2'b00)
               || a_addr < BASE || off >= SPAN;
  always_comb begin
    b = 8'(word >> {a_addr[1:0], 3'b000});
    h = a_addr[1] ? word[31:16] : word[15:0];
    ext = a_size == 2'b01 ? (a_uns ? {24'b0, b} : {{24{b[7]}}, b})
        : a_size == 2'b10 ? (a_uns ? {16'b0, h} : {{16{h[15]}}, h}) : word;
    mask = a_size == 2'b01 ? 4'b0001 << a_addr[1:0] : a_size == 2'b10 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = a_size == 2'b01 ? {4{a_wdata[7:0]}} : a_size == 2'b10 ? {2{a_wdata[15:0]}} : a_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= fire ? 4'(LATENCY - 1) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (fire) begin
        l_wen <= bus.req_wen;
        l_uns <= bus.req_unsigned;
        l_size <= bus.req_size;
        l_addr <= bus.req_addr;
        l_wdata <= bus.req_wdata;
      end
      if (acc) begin
        rdata_q <= err || a_wen ? 32'd0 : ext;
        err_q <= err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && acc && a_wen && !err)
      for (int i = 0; i < 4; i++)
        if (mask[i]) ram[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = fire ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
      WAIT: state_n = cnt == 4'd0 ? RESP : WAIT;
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err = err_q;
  end
endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// tb_ysyx_23060042_lsu: directed checks of the LSU at latency 2 (main) and latency 3 (reset mid-store)
module tb_ysyx_23060042_lsu;
  logic clk = 0;
  logic rst = 1;
  int sel = 0;
  logic req_valid = 0, req_wen = 0, req_unsigned = 0, rsp_ready = 1;
  logic [1:0] req_size = 2'b11;
  logic [31:0] req_addr = 32'h80000000, req_wdata = 0;
  logic vld, rdy, er;
  logic [31:0] rd, dat;
  int nchk = 0, nerr = 0;
  ysyx_23060042_lsu_if i2 ();
  ysyx_23060042_lsu_if i3 ();
  ysyx_23060042_lsu #(.LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  ysyx_23060042_lsu #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
  assign i2.req_valid = req_valid && sel == 0;
  assign i3.req_valid = req_valid && sel == 1;
  assign {i2.req_wen, i2.req_size, i2.req_unsigned, i2.req_addr, i2.req_wdata, i2.rsp_ready} = {req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready};
  assign {i3.req_wen, i3.req_size, i3.req_unsigned, i3.req_addr, i3.req_wdata, i3.rsp_ready} = {req_wen, req_size, req_unsigned, req_addr, req_wdata, rsp_ready};
  assign vld = sel == 1 ? i3.rsp_valid : i2.rsp_valid;
  assign rdy = sel == 1 ? i3.req_ready : i2.req_ready;
  assign dat = sel == 1 ? i3.rsp_rdata : i2.rsp_rdata;
  assign er = sel == 1 ? i3.rsp_err : i2.rsp_err;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] d, input int bp, output logic [31:0] r, output logic e);
    int n;
    logic [31:0] hold;
    rsp_ready = bp == 0;
    check({tag, " ready"}, {31'b0, rdy}, 1);
    req_valid = 1; req_wen = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, sel == 1 ? 3 : 2);
    hold = dat;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check({tag, " bp valid"}, {31'b0, vld}, 1);
      check({tag, " bp rdata"}, dat, hold);
      check({tag, " bp ready"}, {31'b0, rdy}, 0);
    end
    rsp_ready = 1;
    r = dat;
    e = er;
    @(posedge clk); #1;
    check({tag, " done"}, {30'b0, vld, rdy}, 32'b01);
  endtask
  task automatic ld(input string tag, input logic [1:0] sz, input logic u, input logic [31:0] a,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] r;
    logic e;
    xact(tag, 0, sz, u, a, 0, 0, r, e);
    check({tag, " rdata"}, r, exp_d);
    check({tag, " err"}, {31'b0, e}, {31'b0, exp_e});
  endtask
  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic exp_e);
    logic [31:0] r;
    logic e;
    xact(tag, 1, sz, 0, a, d, 0, r, e);
    check({tag, " rdata"}, r, 0);
    check({tag, " err"}, {31'b0, e}, {31'b0, exp_e});
  endtask
  initial begin
    logic [31:0] r;
    logic e;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'b0, vld}, 0);
    check("reset rdata", dat, 0);
    check("reset err", {31'b0, er}, 0);
    check("reset ready", {31'b0, rdy}, 1);
    rst = 0;
    st("st word", 2'b11, 32'h80000010, 32'hDEADBEEF, 0);
    ld("ld word", 2'b11, 0, 32'h80000010, 32'hDEADBEEF, 0);
    st("st ext", 2'b11, 32'h80000020, 32'h80FF7F01, 0);
    ld("lb s 22", 2'b01, 0, 32'h80000022, 32'hFFFFFFFF, 0);
    ld("lbu 22", 2'b01, 1, 32'h80000022, 32'h000000FF, 0);
    ld("lh s 22", 2'b10, 0, 32'h80000022, 32'hFFFF80FF, 0);
    ld("lhu 22", 2'b10, 1, 32'h80000022, 32'h000080FF, 0);
    ld("lb s 21", 2'b01, 0, 32'h80000021, 32'h0000007F, 0);
    ld("lh s 20", 2'b10, 0, 32'h80000020, 32'h00007F01, 0);
    st("st base", 2'b11, 32'h80000020, 32'h11223344, 0);
    st("sb 23", 2'b01, 32'h80000023, 32'h000000AB, 0);
    ld("ld sb", 2'b11, 0, 32'h80000020, 32'hAB223344, 0);
    st("sh 12", 2'b10, 32'h80000012, 32'h0000CAFE, 0);
    ld("ld sh", 2'b11, 0, 32'h80000010, 32'hCAFEBEEF, 0);
    st("st w0", 2'b11, 32'h80000000, 32'h55AA55AA, 0);
    st("st last", 2'b11, 32'h80003FFC, 32'hCAFEF00D, 0);
    ld("lh mis", 2'b10, 0, 32'h80000001, 32'h0, 1);
    ld("ld w0", 2'b11, 0, 32'h80000000, 32'h55AA55AA, 0);
    st("st low", 2'b11, 32'h7FFFFFFC, 32'h99999999, 1);
    ld("ld last", 2'b11, 0, 32'h80003FFC, 32'hCAFEF00D, 0);
    st("st sz0", 2'b00, 32'h80000020, 32'hFFFFFFFF, 1);
    st("sw mis", 2'b11, 32'h80000022, 32'hFFFFFFFF, 1);
    ld("ld chk", 2'b11, 0, 32'h80000020, 32'hAB223344, 0);
    ld("ld sz0", 2'b00, 0, 32'h80000020, 32'h0, 1);
    ld("ld high", 2'b11, 0, 32'h80004000, 32'h0, 1);
    xact("bp", 0, 2'b11, 0, 32'h80000010, 0, 5, r, e);
    check("bp rdata", r, 32'hCAFEBEEF);
    check("bp err", {31'b0, e}, 0);
    sel = 1;
    st("r3 clear", 2'b11, 32'h80000040, 32'h0, 0);
    req_valid = 1; req_wen = 1; req_size = 2'b11; req_unsigned = 0; req_addr = 32'h80000040; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst valid", {31'b0, vld}, 0);
    check("rst ready", {31'b0, rdy}, 1);
    repeat (4) @(posedge clk);
    #1;
    ld("rst ld", 2'b11, 0, 32'h80000040, 32'h0, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
